// File: rtl/wb_commit_queue.sv
// Writeback commit queue: builds the GRF write at MEM, queues it and
// offers it to the register file in order, with a forwarding lookup.
module wb_commit_queue #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 2,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [1:0]        dst_sel,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        src_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_out,
    input  logic [DATA_W-1:0] pc,
    input  logic [15:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addrQ [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;

    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] newAddr;
    logic [DATA_W-1:0] newData;
    logic [1:0]        off;
    logic [7:0]        ldByte;
    logic [15:0]       ldHalf;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign off    = alu_out[1:0];
    assign ldByte = mem_out[{off, 3'b000} +: 8];
    assign ldHalf = mem_out[{off[1], 4'b0000} +: 16];

    always_comb begin
        newAddr = '0;
        unique case (dst_sel)
            2'b00: newAddr = rd_addr;
            2'b01: newAddr = rt_addr;
            2'b10: newAddr = ADDR_W'(LINK_REG);
            2'b11: newAddr = '0;
        endcase
    end

    always_comb begin
        newData = '0;
        unique case (src_sel)
            3'b000: newData = alu_out;
            3'b001: newData = mem_out;
            3'b010: newData = pc + DATA_W'(8);
            3'b011: newData = DATA_W'({imm, 16'h0000});
            3'b100: newData = {{(DATA_W-8){ldByte[7]}}, ldByte};
            3'b101: newData = {{(DATA_W-8){1'b0}}, ldByte};
            3'b110: newData = {{(DATA_W-16){ldHalf[15]}}, ldHalf};
            3'b111: newData = {{(DATA_W-16){1'b0}}, ldHalf};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else if (flush) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset; validity lives entirely in count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            addrQ[wrPtr] <= newAddr;
            dataQ[wrPtr] <= newData;
        end
    end

    assign out_addr = out_valid ? addrQ[rdPtr] : '0;
    assign out_data = out_valid ? dataQ[rdPtr] : '0;
    assign out_we   = out_valid && (out_addr != '0);

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (fwd_addr != '0) &&
                (addrQ[rdPtr + PTR_W'(i)] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = dataQ[rdPtr + PTR_W'(i)];
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue at default parameters.
module tb_wb_commit_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [1:0]  dst_sel;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [2:0]  src_sel;
    logic [31:0] alu_out;
    logic [31:0] mem_out;
    logic [31:0] pc;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic        out_we;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int total = 0;
    int bad = 0;

    wb_commit_queue dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .dst_sel(dst_sel), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .src_sel(src_sel), .alu_out(alu_out), .mem_out(mem_out),
        .pc(pc), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we),
        .out_addr(out_addr), .out_data(out_data),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [1:0] d, input logic [2:0] s,
                       input logic [4:0] rd, input logic [4:0] rt,
                       input logic [31:0] a, input logic [31:0] m,
                       input logic [31:0] p, input logic [15:0] i);
        in_valid = 1'b1;
        dst_sel  = d;
        src_sel  = s;
        rd_addr  = rd;
        rt_addr  = rt;
        alu_out  = a;
        mem_out  = m;
        pc       = p;
        imm      = i;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        fwd_addr  = 5'd0;
        put(2'b00, 3'b000, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0);
        in_valid  = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_we", 32'(out_we), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);

        // basic alu write, head next cycle then drained
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        put(2'b00, 3'b000, 5'd8, 5'd0, 32'h12345678, 32'h0, 32'h0, 16'h0);
        tick;
        in_valid = 1'b0;
        chk("alu_valid", 32'(out_valid), 32'd1);
        chk("alu_we", 32'(out_we), 32'd1);
        chk("alu_addr", 32'(out_addr), 32'd8);
        chk("alu_data", out_data, 32'h12345678);
        tick;
        chk("alu_empty", 32'(out_valid), 32'd0);
        chk("empty_addr", 32'(out_addr), 32'd0);
        chk("empty_data", out_data, 32'd0);

        // loads, streamed with push and pop on the same edge
        put(2'b00, 3'b100, 5'd4, 5'd0, 32'h3, 32'h80FF7F01, 32'h0, 16'h0);
        tick;
        chk("lb_data", out_data, 32'hFFFFFF80);
        put(2'b00, 3'b101, 5'd4, 5'd0, 32'h3, 32'h80FF7F01, 32'h0, 16'h0);
        tick;
        chk("lbu_data", out_data, 32'h00000080);
        chk("pushpop_ready", 32'(in_ready), 32'd1);
        put(2'b00, 3'b110, 5'd4, 5'd0, 32'h2, 32'h80FF7F01, 32'h0, 16'h0);
        tick;
        chk("lh_data", out_data, 32'hFFFF80FF);
        put(2'b00, 3'b111, 5'd4, 5'd0, 32'h1, 32'h80FF7F01, 32'h0, 16'h0);
        tick;
        chk("lhu_data", out_data, 32'h00007F01);
        put(2'b00, 3'b101, 5'd4, 5'd0, 32'h0, 32'h80FF7F01, 32'h0, 16'h0);
        tick;
        chk("lbu0_data", out_data, 32'h00000001);
        put(2'b01, 3'b011, 5'd4, 5'd12, 32'h0, 32'h0, 32'h0, 16'hBEEF);
        tick;
        chk("lui_data", out_data, 32'hBEEF0000);
        chk("rt_addr", 32'(out_addr), 32'd12);
        put(2'b00, 3'b001, 5'd6, 5'd0, 32'h0, 32'hCAFEF00D, 32'h0, 16'h0);
        tick;
        chk("mem_data", out_data, 32'hCAFEF00D);
        in_valid = 1'b0;
        tick;
        chk("load_empty", 32'(out_valid), 32'd0);

        // backpressure: fill, refuse third, drain in order
        out_ready = 1'b0;
        put(2'b00, 3'b000, 5'd1, 5'd0, 32'h11, 32'h0, 32'h0, 16'h0);
        tick;
        put(2'b00, 3'b000, 5'd2, 5'd0, 32'h22, 32'h0, 32'h0, 16'h0);
        tick;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_addr", 32'(out_addr), 32'd1);
        put(2'b00, 3'b000, 5'd3, 5'd0, 32'h33, 32'h0, 32'h0, 16'h0);
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("drain1_addr", 32'(out_addr), 32'd2);
        chk("drain1_data", out_data, 32'h22);
        chk("drain1_ready", 32'(in_ready), 32'd1);
        tick;
        chk("drain_empty", 32'(out_valid), 32'd0);

        // link write, then a no-write entry
        put(2'b10, 3'b010, 5'd4, 5'd0, 32'h0, 32'h0, 32'h00003000, 16'h0);
        tick;
        chk("link_addr", 32'(out_addr), 32'd31);
        chk("link_data", out_data, 32'h00003008);
        chk("link_we", 32'(out_we), 32'd1);
        put(2'b11, 3'b000, 5'd7, 5'd0, 32'h55, 32'h0, 32'h0, 16'h0);
        tick;
        in_valid = 1'b0;
        chk("nowr_valid", 32'(out_valid), 32'd1);
        chk("nowr_we", 32'(out_we), 32'd0);
        chk("nowr_addr", 32'(out_addr), 32'd0);
        tick;
        chk("nowr_popped", 32'(out_valid), 32'd0);
        put(2'b10, 3'b010, 5'd4, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFC, 16'h0);
        tick;
        in_valid = 1'b0;
        chk("pc_wrap", out_data, 32'h00000004);
        tick;

        // forwarding picks the youngest match
        out_ready = 1'b0;
        put(2'b00, 3'b000, 5'd5, 5'd0, 32'hA, 32'h0, 32'h0, 16'h0);
        tick;
        put(2'b00, 3'b000, 5'd5, 5'd0, 32'hB, 32'h0, 32'h0, 16'h0);
        tick;
        in_valid = 1'b0;
        fwd_addr = 5'd5;
        #1;
        chk("fwd_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_data", fwd_data, 32'hB);
        fwd_addr = 5'd0;
        #1;
        chk("fwd0_hit", 32'(fwd_hit), 32'd0);
        chk("fwd0_data", fwd_data, 32'd0);
        fwd_addr = 5'd6;
        #1;
        chk("fwd6_hit", 32'(fwd_hit), 32'd0);

        // flush beats a push on a full queue
        fwd_addr = 5'd5;
        flush = 1'b1;
        put(2'b00, 3'b000, 5'd9, 5'd0, 32'h99, 32'h0, 32'h0, 16'h0);
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        chk("flush_fwd", 32'(fwd_hit), 32'd0);
        tick;
        chk("flush_stays", 32'(out_valid), 32'd0);

        // reset in the middle of draining
        put(2'b00, 3'b000, 5'd10, 5'd0, 32'h100, 32'h0, 32'h0, 16'h0);
        tick;
        put(2'b00, 3'b000, 5'd11, 5'd0, 32'h101, 32'h0, 32'h0, 16'h0);
        tick;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        chk("prerst_addr", 32'(out_addr), 32'd11);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_we", 32'(out_we), 32'd0);
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        put(2'b00, 3'b000, 5'd12, 5'd0, 32'h200, 32'h0, 32'h0, 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("post_rst_addr", 32'(out_addr), 32'd12);
        chk("post_rst_data", out_data, 32'h200);
        tick;
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
